// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan controller: segment bit positions
// and the active-high hex glyph table.
package seg7_pkg;

   localparam int SEG_A  = 0;
   localparam int SEG_B  = 1;
   localparam int SEG_C  = 2;
   localparam int SEG_D  = 3;
   localparam int SEG_E  = 4;
   localparam int SEG_F  = 5;
   localparam int SEG_G  = 6;
   localparam int SEG_DP = 7;

   localparam logic [7:0] SEG_OFF = 8'h00;

   // Active-high g..a patterns for hex digits 0..F.
   localparam logic [6:0] HEX_SEG [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

endpackage

// File: rtl/seg7_decode.sv
// Hex nibble plus decimal point to active-high segment vector
// (bit 7 = dp, bits 6:0 = g..a).
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nibble_i,
   input  logic       dp_i,
   output logic [7:0] seg_o
);

   always_comb begin
      seg_o                = SEG_OFF;
      seg_o[SEG_G:SEG_A]   = HEX_SEG[nibble_i];
      seg_o[SEG_DP]        = dp_i;
   end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scanner with frame-synchronous double buffering,
// leading-zero suppression, blanking/blinking and anti-ghost dead time.
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS     = 8,
   parameter int DIV_BITS       = 15,
   parameter int DEAD_CYCLES    = 4,
   parameter int BLINK_BITS     = 24,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit SEL_ACTIVE_LOW = 1'b1
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] inputData,
   input  logic [NUM_DIGITS-1:0]   dpIn,
   input  logic [NUM_DIGITS-1:0]   blankMask,
   input  logic [NUM_DIGITS-1:0]   blinkMask,
   input  logic                    lzSuppress,
   output logic [7:0]              tubeChar,
   output logic [NUM_DIGITS-1:0]   tubeSelect,
   output logic                    frameDone
);

   localparam int IDX_W  = $clog2(NUM_DIGITS);
   localparam int DEAD_W = (DEAD_CYCLES > 0) ? $clog2(DEAD_CYCLES + 1) : 1;
   localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
   localparam logic [DEAD_W-1:0]     DEAD_INIT = DEAD_W'(DEAD_CYCLES);
   localparam logic [7:0]            CHAR_POL  = {8{SEG_ACTIVE_LOW}};
   localparam logic [NUM_DIGITS-1:0] SEL_POL   = {NUM_DIGITS{SEL_ACTIVE_LOW}};
   localparam logic [NUM_DIGITS-1:0] SEL_ONE   = NUM_DIGITS'(1);

   logic [DIV_BITS-1:0]     presc_q, presc_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [BLINK_BITS-1:0]   blink_q, blink_d;
   logic [DEAD_W-1:0]       dead_q, dead_d;
   logic [4*NUM_DIGITS-1:0] stg_data_q, stg_data_d, dsp_data_q, dsp_data_d;
   logic [NUM_DIGITS-1:0]   stg_dp_q, stg_dp_d, dsp_dp_q, dsp_dp_d;
   logic [NUM_DIGITS-1:0]   stg_blank_q, stg_blank_d, dsp_blank_q, dsp_blank_d;
   logic [NUM_DIGITS-1:0]   stg_blink_q, stg_blink_d, dsp_blink_q, dsp_blink_d;
   logic                    stg_lz_q, stg_lz_d, dsp_lz_q, dsp_lz_d;
   logic                    pending_q, pending_d;
   logic [7:0]              char_q, char_d;
   logic [NUM_DIGITS-1:0]   sel_q, sel_d;
   logic                    frame_done_q, frame_done_d;

   logic                    tick, wrap, dark;
   logic [3:0]              cur_nibble;
   logic                    cur_dp;
   logic [7:0]              dec_seg, seg_hi;
   logic [NUM_DIGITS-1:0]   sel_hi;
   logic [NUM_DIGITS:1]     lz_chain;
   logic [NUM_DIGITS-1:0]   suppressed;

   // Suppression ripples down from the top digit while digits stay zero.
   assign lz_chain[NUM_DIGITS] = dsp_lz_q;
   generate
      for (genvar gi = NUM_DIGITS - 1; gi >= 1; gi--) begin : g_lz
         assign lz_chain[gi] = lz_chain[gi+1] & (dsp_data_q[4*gi +: 4] == 4'h0);
      end
   endgenerate
   assign suppressed = {lz_chain[NUM_DIGITS-1:1], 1'b0};

   assign cur_nibble = dsp_data_q[{idx_q, 2'b00} +: 4];
   assign cur_dp     = dsp_dp_q[idx_q];

   seg7_decode u_decode (
      .nibble_i (cur_nibble),
      .dp_i     (cur_dp),
      .seg_o    (dec_seg)
   );

   always_comb begin
      tick         = &presc_q;
      wrap         = tick && (idx_q == LAST_IDX);
      presc_d      = presc_q + 1'b1;
      blink_d      = blink_q + 1'b1;
      idx_d        = idx_q;
      dead_d       = dead_q;
      stg_data_d   = stg_data_q;
      stg_dp_d     = stg_dp_q;
      stg_blank_d  = stg_blank_q;
      stg_blink_d  = stg_blink_q;
      stg_lz_d     = stg_lz_q;
      dsp_data_d   = dsp_data_q;
      dsp_dp_d     = dsp_dp_q;
      dsp_blank_d  = dsp_blank_q;
      dsp_blink_d  = dsp_blink_q;
      dsp_lz_d     = dsp_lz_q;
      pending_d    = pending_q;
      frame_done_d = wrap;

      if (tick) begin
         idx_d  = wrap ? '0 : idx_q + 1'b1;
         dead_d = DEAD_INIT;
      end else if (dead_q != '0) begin
         dead_d = dead_q - 1'b1;
      end

      if (load) begin
         stg_data_d  = inputData;
         stg_dp_d    = dpIn;
         stg_blank_d = blankMask;
         stg_blink_d = blinkMask;
         stg_lz_d    = lzSuppress;
         pending_d   = 1'b1;
      end

      // A load on the commit tick bypasses staging so the fresh values win.
      if (wrap) begin
         pending_d = 1'b0;
         if (load) begin
            dsp_data_d  = inputData;
            dsp_dp_d    = dpIn;
            dsp_blank_d = blankMask;
            dsp_blink_d = blinkMask;
            dsp_lz_d    = lzSuppress;
         end else if (pending_q) begin
            dsp_data_d  = stg_data_q;
            dsp_dp_d    = stg_dp_q;
            dsp_blank_d = stg_blank_q;
            dsp_blink_d = stg_blink_q;
            dsp_lz_d    = stg_lz_q;
         end
      end

      dark   = dsp_blank_q[idx_q] | (dsp_blink_q[idx_q] & blink_q[BLINK_BITS-1])
             | suppressed[idx_q];
      seg_hi = dark ? SEG_OFF : dec_seg;
      sel_hi = (dead_q != '0) ? '0 : (SEL_ONE << idx_q);
      char_d = seg_hi ^ CHAR_POL;
      sel_d  = sel_hi ^ SEL_POL;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         presc_q      <= '0;
         idx_q        <= '0;
         blink_q      <= '0;
         dead_q       <= DEAD_INIT;
         stg_data_q   <= '0;
         stg_dp_q     <= '0;
         stg_blank_q  <= '0;
         stg_blink_q  <= '0;
         stg_lz_q     <= 1'b0;
         dsp_data_q   <= '0;
         dsp_dp_q     <= '0;
         dsp_blank_q  <= '0;
         dsp_blink_q  <= '0;
         dsp_lz_q     <= 1'b0;
         pending_q    <= 1'b0;
         char_q       <= SEG_OFF ^ CHAR_POL;
         sel_q        <= SEL_POL;
         frame_done_q <= 1'b0;
      end else begin
         presc_q      <= presc_d;
         idx_q        <= idx_d;
         blink_q      <= blink_d;
         dead_q       <= dead_d;
         stg_data_q   <= stg_data_d;
         stg_dp_q     <= stg_dp_d;
         stg_blank_q  <= stg_blank_d;
         stg_blink_q  <= stg_blink_d;
         stg_lz_q     <= stg_lz_d;
         dsp_data_q   <= dsp_data_d;
         dsp_dp_q     <= dsp_dp_d;
         dsp_blank_q  <= dsp_blank_d;
         dsp_blink_q  <= dsp_blink_d;
         dsp_lz_q     <= dsp_lz_d;
         pending_q    <= pending_d;
         char_q       <= char_d;
         sel_q        <= sel_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign tubeChar   = char_q;
   assign tubeSelect = sel_q;
   assign frameDone  = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with 4 digits, 4-clock scan ticks, one dead
// cycle and a 16-clock blink period; kk counts clock edges since reset release.
module tb_seg7_scan_ctrl;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        load = 1'b0;
   logic [15:0] inputData = '0;
   logic [3:0]  dpIn = '0;
   logic [3:0]  blankMask = '0;
   logic [3:0]  blinkMask = '0;
   logic        lzSuppress = 1'b0;
   logic [7:0]  tubeChar;
   logic [3:0]  tubeSelect;
   logic        frameDone;

   int n_cmp  = 0;
   int n_err  = 0;
   int kk     = 0;
   int fd_cnt = 0;
   int fd0    = 0;

   always #5 CLK = ~CLK;

   seg7_scan_ctrl #(
      .NUM_DIGITS     (4),
      .DIV_BITS       (2),
      .DEAD_CYCLES    (1),
      .BLINK_BITS     (4),
      .SEG_ACTIVE_LOW (1'b1),
      .SEL_ACTIVE_LOW (1'b1)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .load       (load),
      .inputData  (inputData),
      .dpIn       (dpIn),
      .blankMask  (blankMask),
      .blinkMask  (blinkMask),
      .lzSuppress (lzSuppress),
      .tubeChar   (tubeChar),
      .tubeSelect (tubeSelect),
      .frameDone  (frameDone)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (kk=%0d)", tag, got, exp, kk);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
      kk++;
      if (frameDone) fd_cnt++;
   endtask

   task automatic run_to(input int target);
      while (kk < target) step();
   endtask

   task automatic do_load(input logic [15:0] data, input logic [3:0] dp, input logic [3:0] blank,
                          input logic [3:0] blink, input logic lz);
      inputData  = data;
      dpIn       = dp;
      blankMask  = blank;
      blinkMask  = blink;
      lzSuppress = lz;
      load       = 1'b1;
      $display("load @kk=%0d data=%h dp=%b blank=%b blink=%b lz=%0d", kk + 1, data, dp, blank, blink, lz);
      step();
      load = 1'b0;
   endtask

   // base = kk at which digit 0 first appears with selects off.
   task automatic check_frame(input string tag, input int base, input logic [7:0] e0,
                              input logic [7:0] e1, input logic [7:0] e2, input logic [7:0] e3);
      logic [7:0] exp_c [4];
      logic [3:0] oh;
      exp_c = '{e0, e1, e2, e3};
      for (int d = 0; d < 4; d++) begin
         run_to(base + 4*d);
         check_val($sformatf("%s d%0d dead_sel", tag, d), tubeSelect, 4'hF);
         check_val($sformatf("%s d%0d dead_char", tag, d), tubeChar, exp_c[d]);
         run_to(base + 4*d + 1);
         oh = 4'b0001 << d;
         oh = ~oh;
         check_val($sformatf("%s d%0d sel", tag, d), tubeSelect, oh);
         check_val($sformatf("%s d%0d char", tag, d), tubeChar, exp_c[d]);
      end
      $display("frame %s checked from kk=%0d", tag, base);
   endtask

   initial begin
      RST = 1'b1;
      repeat (3) step();
      check_val("rst char", tubeChar, 8'hFF);
      check_val("rst sel", tubeSelect, 4'hF);
      check_val("rst fd", frameDone, 1'b0);
      RST = 1'b0;
      kk  = 0;

      step();
      check_val("boot dead_sel", tubeSelect, 4'hF);
      check_val("boot char", tubeChar, 8'hC0);
      step();
      check_val("boot sel", tubeSelect, 4'hE);
      check_val("boot char2", tubeChar, 8'hC0);

      run_to(5);
      do_load(16'h1234, 4'h0, 4'h0, 4'h0, 1'b0);
      run_to(10);
      check_val("no_tear char", tubeChar, 8'hC0);
      run_to(15);
      check_val("fd before wrap", frameDone, 1'b0);
      step();
      check_val("fd at wrap", frameDone, 1'b1);
      step();
      check_val("fd after wrap", frameDone, 1'b0);
      fd0 = fd_cnt;
      check_frame("h1234", 17, 8'h99, 8'hB0, 8'hA4, 8'hF9);

      run_to(40);
      do_load(16'h0050, 4'h0, 4'h0, 4'h0, 1'b1);
      run_to(48);
      check_val("fd per frame", fd_cnt - fd0, 2);
      check_frame("lz", 49, 8'hC0, 8'h92, 8'hFF, 8'hFF);

      run_to(70);
      do_load(16'h8888, 4'b0100, 4'b0010, 4'b0001, 1'b0);
      check_frame("mask", 81, 8'h80, 8'hFF, 8'h00, 8'h80);

      run_to(100);
      do_load(16'h5678, 4'h0, 4'h0, 4'hF, 1'b0);
      check_frame("blink", 113, 8'h80, 8'hF8, 8'hFF, 8'hFF);

      run_to(130);
      do_load(16'h1111, 4'h0, 4'h0, 4'h0, 1'b0);
      run_to(143);
      do_load(16'hABCD, 4'h0, 4'h0, 4'h0, 1'b0);
      check_frame("commit", 145, 8'hA1, 8'hC6, 8'h83, 8'h88);
      check_frame("hold", 161, 8'hA1, 8'hC6, 8'h83, 8'h88);

      run_to(170);
      do_load(16'h9999, 4'hF, 4'h0, 4'h0, 1'b0);
      run_to(172);
      RST = 1'b1;
      step();
      step();
      check_val("rst2 char", tubeChar, 8'hFF);
      check_val("rst2 sel", tubeSelect, 4'hF);
      check_val("rst2 fd", frameDone, 1'b0);
      RST = 1'b0;
      kk  = 0;
      check_frame("post_rst", 1, 8'hC0, 8'hC0, 8'hC0, 8'hC0);
      check_frame("post_rst2", 17, 8'hC0, 8'hC0, 8'hC0, 8'hC0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8, number of multiplexed digits (2..16).
REQ-002 SHALL have parameter DIV_BITS, default 15, prescaler width; one scan tick every 2^DIV_BITS clocks.
REQ-003 SHALL have parameter DEAD_CYCLES, default 4, anti-ghost cycles with all selects inactive after each digit change (0..2^DIV_BITS-1).
REQ-004 SHALL have parameter BLINK_BITS, default 24, blink counter width; blink phase = counter MSB.
REQ-005 SHALL have parameters SEG_ACTIVE_LOW, default 1, and SEL_ACTIVE_LOW, default 1, output polarities.
REQ-006 SHALL have port CLK  in  1  single clock, all logic on rising edge.
REQ-007 SHALL have port RST  in  1  reset, synchronous and active-high.
REQ-008 SHALL have port load  in  1  one-cycle strobe capturing inputData, dpIn, blankMask, blinkMask, lzSuppress into staging registers.
REQ-009 SHALL have port inputData  in  4*NUM_DIGITS  hex nibbles, digit i = bits [4i+3:4i].
REQ-010 SHALL have port dpIn  in  NUM_DIGITS  decimal point on per digit.
REQ-011 SHALL have port blankMask  in  NUM_DIGITS  1 = digit forced dark.
REQ-012 SHALL have port blinkMask  in  NUM_DIGITS  1 = digit dark while blink phase = 1.
REQ-013 SHALL have port lzSuppress  in  1  enable leading-zero suppression.
REQ-014 SHALL have port tubeChar  out  8  segments, bit7 = dp, bits6:0 = g..a.
REQ-015 SHALL have port tubeSelect  out  NUM_DIGITS  one-hot digit enable (polarity per SEL_ACTIVE_LOW).
REQ-016 SHALL have port frameDone  out  1  one-cycle pulse when digit index wraps NUM_DIGITS-1 -> 0.

Function
REQ-017 Prescaler SHALL count every clock, wrap at 2^DIV_BITS-1; terminal count = tick.
REQ-018 Digit index SHALL advance by 1 on tick, wrapping from NUM_DIGITS-1 to 0.
REQ-019 load SHALL write staging registers; pending flag set until commit.
REQ-020 Display registers SHALL update from staging only on the tick where index wraps to 0 (frame boundary), clearing pending; no mid-frame tearing.
REQ-021 load coincident with commit tick SHALL commit the newly presented inputs directly; pending SHALL end 0.
REQ-022 Leading-zero suppression (lzSuppress=1): digits from NUM_DIGITS-1 downward with value 0 SHALL be dark until first nonzero digit; digit 0 never suppressed; dp of suppressed digit also dark.
REQ-023 Digit dark if blankMask[i], or blinkMask[i] and blink phase=1, or suppressed; dark = all 8 segments inactive.
REQ-024 Hex decode SHALL map 0..F to standard a..g patterns (active-low: C0,F9,A4,B0,99,92,82,F8,80,90,88,83,C6,A1,86,8E with dp off); dp on clears bit7 when active-low.
REQ-025 tubeChar and tubeSelect SHALL be registered, one clock after index change.
REQ-026 For DEAD_CYCLES clocks after each index change tubeSelect SHALL be all inactive; tubeChar SHALL already show the new digit.
REQ-027 Blink counter SHALL free-run and wrap; independent of prescaler.
REQ-028 Polarity parameters SHALL invert outputs only; internal logic active-high.

Reset
REQ-029 RST SHALL clear prescaler, index, blink counter, staging, display registers, pending to 0.
REQ-030 During and after RST: tubeChar all segments inactive (FF when SEG_ACTIVE_LOW), tubeSelect all inactive, frameDone 0.
REQ-031 RST mid-frame SHALL discard pending staged data; first digit after reset is digit 0 showing 0.

Structure
REQ-032 Package seg7_pkg SHALL hold the 16-entry hex-to-segment table, SEG_OFF constant and segment bit-index constants.
REQ-033 Sub-module seg7_decode SHALL implement nibble+dp -> active-high 8-bit segments; polarity applied in seg7_scan_ctrl.

Verification (NUM_DIGITS=4, DIV_BITS=2, DEAD_CYCLES=1, BLINK_BITS=4, active-low)
REQ-034 RST 3 clocks -> tubeChar=FF, tubeSelect=F, frameDone=0; after release digit 0 selected (E) with C0 after DEAD_CYCLES.
REQ-035 load inputData=16'h1234 mid-frame -> display unchanged until wrap; next frame digits 0..3 show 99,B0,A4,F9; frameDone pulses once per 16 clocks.
REQ-036 inputData=16'h0050, lzSuppress=1 -> digit3,digit2 FF; digit1 92; digit0 C0.
REQ-037 blinkMask=4'b0001 -> digit 0 alternates FF/pattern every 8 clocks; blankMask=4'b0010 -> digit1 always FF; dpIn[2]=1 -> bit7=0 on digit2.
REQ-038 load on commit tick with 16'hABCD -> next frame shows D,C,B,A directly (A1,C6,83,88), pending=0; RST asserted mid-frame after load -> old staged data never shown.
REQ-039 Each index change -> tubeSelect=F for exactly 1 clock, then one-hot low.
